// File: rtl/axi4_burst_traffic_master_if.sv
`timescale 1ns/1ps
// AXI4 channel bundle between the burst traffic master and the interconnect slave port.
// The master modport drives AW/W/AR and the B/R ready strobes; the slave modport is the mirror.
interface axi4_burst_traffic_master_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 18
);
  // write address channel
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;
  // write data channel
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;
  // write response channel
  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  // read address channel
  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;
  // read data channel
  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_burst_traffic_master.sv
`timescale 1ns/1ps
// AXI4 burst traffic generator/checker for bring-up.
// A pass writes NUM_BURSTS INCR bursts of a seed+k counting pattern, reads them back and
// compares every beat. Errors are counted (saturating) but never abort the pass.
module axi4_burst_traffic_master #(
  parameter int              ADDR_WIDTH = 16,
  parameter int              DATA_WIDTH = 32,
  parameter int              ID_WIDTH   = 18,
  parameter int unsigned     TXN_ID     = 0,
  parameter int              BURST_LEN  = 16,
  parameter int              NUM_BURSTS = 4,
  parameter longint unsigned BASE_ADDR  = 0
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  resp_err,
  output logic [15:0]           err_count,
  axi4_burst_traffic_master_if.master bus
);

  localparam int                     STRB_WIDTH   = DATA_WIDTH / 8;
  localparam logic [7:0]             LEN_V        = 8'(BURST_LEN - 1);
  localparam logic [2:0]             SIZE_V       = 3'($clog2(STRB_WIDTH));
  localparam logic [ADDR_WIDTH-1:0]  STRIDE_V     = ADDR_WIDTH'(BURST_LEN * STRB_WIDTH);
  localparam logic [ADDR_WIDTH-1:0]  BASE_V       = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ID_WIDTH-1:0]    ID_V         = ID_WIDTH'(TXN_ID);
  localparam logic [15:0]            LAST_BURST_V = 16'(NUM_BURSTS - 1);
  localparam logic [DATA_WIDTH-1:0]  ONE_V        = {{(DATA_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [STRB_WIDTH-1:0]  STRB_ALL_V   = {STRB_WIDTH{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WA   = 3'd1,
    ST_WD   = 3'd2,
    ST_WB   = 3'd3,
    ST_RA   = 3'd4,
    ST_RD   = 3'd5,
    ST_DONE = 3'd6
  } state_t;

  // saturating error-count increment; the count pins at all-ones
  function automatic logic [15:0] sat_inc(input logic [15:0] value, input logic hit);
    if (hit && (value != 16'hFFFF)) begin
      return value + 16'd1;
    end else begin
      return value;
    end
  endfunction

  state_t                  state_r;
  logic [15:0]             burst_r;
  logic [7:0]              beat_r;
  logic [DATA_WIDTH-1:0]   seed_r;
  logic [DATA_WIDTH-1:0]   wpat_r;
  logic [DATA_WIDTH-1:0]   rpat_r;
  logic [ADDR_WIDTH-1:0]   awaddr_r;
  logic [ADDR_WIDTH-1:0]   araddr_r;
  logic                    awvalid_r;
  logic                    wvalid_r;
  logic                    wlast_r;
  logic                    bready_r;
  logic                    arvalid_r;
  logic                    rready_r;
  logic                    busy_r;
  logic                    done_r;
  logic                    pass_r;
  logic                    resp_err_r;
  logic [15:0]             err_count_r;

  logic                    err_hit_s;
  logic                    resp_hit_s;
  logic [15:0]             err_next_s;

  // classify the response beat accepted this cycle (B in WB, R in RD) as error / response error
  always_comb begin
    err_hit_s  = 1'b0;
    resp_hit_s = 1'b0;
    case (state_r)
      ST_WB: begin
        if (bus.BVALID) begin
          err_hit_s  = (bus.BRESP != 2'b00) || (bus.BID != ID_V);
          resp_hit_s = (bus.BRESP != 2'b00);
        end else begin
          err_hit_s  = 1'b0;
          resp_hit_s = 1'b0;
        end
      end
      ST_RD: begin
        if (bus.RVALID) begin
          err_hit_s  = (bus.RDATA != rpat_r) || (bus.RRESP != 2'b00) ||
                       (bus.RID != ID_V) || (bus.RLAST != (beat_r == LEN_V));
          resp_hit_s = (bus.RRESP != 2'b00);
        end else begin
          err_hit_s  = 1'b0;
          resp_hit_s = 1'b0;
        end
      end
      default: begin
        err_hit_s  = 1'b0;
        resp_hit_s = 1'b0;
      end
    endcase
    err_next_s = sat_inc(err_count_r, err_hit_s);
  end

  // pass sequencer: write phase, read-back phase, one-cycle DONE; all handshake outputs registered
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r     <= ST_IDLE;
      burst_r     <= 16'd0;
      beat_r      <= 8'd0;
      seed_r      <= '0;
      wpat_r      <= '0;
      rpat_r      <= '0;
      awaddr_r    <= '0;
      araddr_r    <= '0;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      wlast_r     <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      resp_err_r  <= 1'b0;
      err_count_r <= 16'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            seed_r      <= seed;
            wpat_r      <= seed;
            err_count_r <= 16'd0;
            resp_err_r  <= 1'b0;
            pass_r      <= 1'b0;
            burst_r     <= 16'd0;
            awaddr_r    <= BASE_V;
            awvalid_r   <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_WA;
          end
        end
        ST_WA: begin
          if (bus.AWREADY) begin
            awvalid_r <= 1'b0;
            wvalid_r  <= 1'b1;
            wlast_r   <= (LEN_V == 8'd0);
            beat_r    <= 8'd0;
            state_r   <= ST_WD;
          end
        end
        ST_WD: begin
          if (bus.WREADY) begin
            wpat_r <= wpat_r + ONE_V;
            if (wlast_r) begin
              wvalid_r <= 1'b0;
              wlast_r  <= 1'b0;
              bready_r <= 1'b1;
              state_r  <= ST_WB;
            end else begin
              beat_r  <= beat_r + 8'd1;
              wlast_r <= ((beat_r + 8'd1) == LEN_V);
            end
          end
        end
        ST_WB: begin
          if (bus.BVALID) begin
            bready_r    <= 1'b0;
            err_count_r <= err_next_s;
            if (resp_hit_s) begin
              resp_err_r <= 1'b1;
            end
            if (burst_r == LAST_BURST_V) begin
              burst_r   <= 16'd0;
              araddr_r  <= BASE_V;
              arvalid_r <= 1'b1;
              rpat_r    <= seed_r;
              state_r   <= ST_RA;
            end else begin
              burst_r   <= burst_r + 16'd1;
              awaddr_r  <= awaddr_r + STRIDE_V;
              awvalid_r <= 1'b1;
              state_r   <= ST_WA;
            end
          end
        end
        ST_RA: begin
          if (bus.ARREADY) begin
            arvalid_r <= 1'b0;
            rready_r  <= 1'b1;
            beat_r    <= 8'd0;
            state_r   <= ST_RD;
          end
        end
        ST_RD: begin
          if (bus.RVALID) begin
            err_count_r <= err_next_s;
            rpat_r      <= rpat_r + ONE_V;
            if (resp_hit_s) begin
              resp_err_r <= 1'b1;
            end
            // burst length is counted locally; a missing or early RLAST does not end the burst
            if (beat_r == LEN_V) begin
              rready_r <= 1'b0;
              if (burst_r == LAST_BURST_V) begin
                done_r  <= 1'b1;
                pass_r  <= (err_next_s == 16'd0);
                state_r <= ST_DONE;
              end else begin
                burst_r   <= burst_r + 16'd1;
                araddr_r  <= araddr_r + STRIDE_V;
                arvalid_r <= 1'b1;
                state_r   <= ST_RA;
              end
            end else begin
              beat_r <= beat_r + 8'd1;
            end
          end
        end
        ST_DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          awvalid_r <= 1'b0;
          wvalid_r  <= 1'b0;
          bready_r  <= 1'b0;
          arvalid_r <= 1'b0;
          rready_r  <= 1'b0;
          busy_r    <= 1'b0;
          done_r    <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

  // static burst attributes are only presented while a pass is active so reset shows all zeros
  assign bus.AWID    = busy_r ? ID_V   : '0;
  assign bus.AWADDR  = awaddr_r;
  assign bus.AWLEN   = busy_r ? LEN_V  : 8'h00;
  assign bus.AWSIZE  = busy_r ? SIZE_V : 3'b000;
  assign bus.AWBURST = busy_r ? 2'b01  : 2'b00;
  assign bus.AWVALID = awvalid_r;
  assign bus.WDATA   = wpat_r;
  assign bus.WSTRB   = busy_r ? STRB_ALL_V : '0;
  assign bus.WLAST   = wlast_r;
  assign bus.WVALID  = wvalid_r;
  assign bus.BREADY  = bready_r;
  assign bus.ARID    = busy_r ? ID_V   : '0;
  assign bus.ARADDR  = araddr_r;
  assign bus.ARLEN   = busy_r ? LEN_V  : 8'h00;
  assign bus.ARSIZE  = busy_r ? SIZE_V : 3'b000;
  assign bus.ARBURST = busy_r ? 2'b01  : 2'b00;
  assign bus.ARVALID = arvalid_r;
  assign bus.RREADY  = rready_r;

  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign resp_err  = resp_err_r;
  assign err_count = err_count_r;

endmodule
